// File: rtl/arb_slave_responder.sv
// Slave endpoint of the arbiter req/ack link: steers each accepted word into one of two
// show-ahead FIFOs, counts accepted words per channel and flags withdrawn requests.
module arb_slave_responder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_arb,
  input  logic             rst_n,
  input  logic             s_req,
  input  logic [31:0]      s_data,
  input  logic             s_sel,
  output logic             s_ack,
  output logic             out0_valid,
  output logic [31:0]      out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [31:0]      out1_data,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] acc_cnt0,
  output logic [CNT_W-1:0] acc_cnt1,
  output logic             proto_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_OCC = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      r_mem  [2][DEPTH];
  logic [PTR_W-1:0] r_wptr [2];
  logic [PTR_W-1:0] r_rptr [2];
  logic [PTR_W:0]   r_occ  [2];
  logic [CNT_W-1:0] r_acc  [2];
  logic             r_ack;
  logic             r_req_d;
  logic             r_ack_d;
  logic             r_err;

  logic [1:0] w_ready;
  logic [1:0] w_full;
  logic [1:0] w_pop;
  logic [1:0] w_push;
  logic       w_accept;

  // Full is judged on the pre-pop occupancy, so a full channel never accepts this edge.
  always_comb begin
    w_ready = {out1_ready, out0_ready};
    w_full  = '0;
    w_pop   = '0;
    for (int c = 0; c < 2; c++) begin
      w_full[c] = (r_occ[c] == FULL_OCC);
      w_pop[c]  = (r_occ[c] != '0) && w_ready[c];
    end
    w_accept = s_req && !r_ack && !w_full[s_sel];
    w_push   = {w_accept & s_sel, w_accept & ~s_sel};
  end

  always_ff @(posedge clk_arb or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_req_d <= 1'b0;
      r_ack_d <= 1'b0;
      r_err   <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_occ[c]  <= '0;
        r_acc[c]  <= '0;
      end
    end else begin
      r_ack   <= w_accept;
      r_req_d <= s_req;
      r_ack_d <= r_ack;
      // Request seen last edge without an ack, and gone now: the arbiter withdrew it.
      if (r_req_d && !r_ack_d && !s_req) r_err <= 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (w_push[c]) begin
          r_wptr[c] <= r_wptr[c] + PTR_ONE;
          r_acc[c]  <= r_acc[c] + CNT_ONE;
        end
        if (w_pop[c]) r_rptr[c] <= r_rptr[c] + PTR_ONE;
        if (w_push[c] && !w_pop[c])      r_occ[c] <= r_occ[c] + OCC_ONE;
        else if (!w_push[c] && w_pop[c]) r_occ[c] <= r_occ[c] - OCC_ONE;
      end
    end
  end

  always_ff @(posedge clk_arb) begin
    for (int c = 0; c < 2; c++) begin
      if (w_push[c]) r_mem[c][r_wptr[c]] <= s_data;
    end
  end

  assign s_ack      = r_ack;
  assign out0_valid = (r_occ[0] != '0);
  assign out1_valid = (r_occ[1] != '0);
  assign out0_data  = r_mem[0][r_rptr[0]];
  assign out1_data  = r_mem[1][r_rptr[1]];
  assign acc_cnt0   = r_acc[0];
  assign acc_cnt1   = r_acc[1];
  assign proto_err  = r_err;

endmodule

// File: tb/tb_arb_slave_responder.sv
// Bench for arb_slave_responder: directed scenarios plus a randomized legal-arbiter run
// compared each cycle against a queue-based reference model.
module tb_arb_slave_responder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk_arb = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_req = 1'b0;
  logic [31:0]      s_data = '0;
  logic             s_sel = 1'b0;
  logic             s_ack;
  logic             out0_valid, out1_valid;
  logic [31:0]      out0_data, out1_data;
  logic             out0_ready = 1'b0, out1_ready = 1'b0;
  logic [CNT_W-1:0] acc_cnt0, acc_cnt1;
  logic             proto_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_arb = ~clk_arb;

  arb_slave_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_arb(clk_arb), .rst_n(rst_n),
    .s_req(s_req), .s_data(s_data), .s_sel(s_sel), .s_ack(s_ack),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
    .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1), .proto_err(proto_err)
  );

  // Reference model: queues per channel, evaluated from the accept/pop rules.
  logic [31:0]      q0[$], q1[$];
  logic [CNT_W-1:0] m_cnt0, m_cnt1;
  bit               m_ack, m_err, m_req_h, m_ack_h, m_acc;

  always @(posedge clk_arb or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_cnt0 = '0; m_cnt1 = '0;
      m_ack = 0; m_err = 0; m_req_h = 0; m_ack_h = 0;
    end else begin
      m_acc = s_req && !m_ack && ((s_sel ? q1.size() : q0.size()) < DEPTH);
      if (m_req_h && !m_ack_h && !s_req) m_err = 1;
      m_req_h = s_req;
      m_ack_h = m_ack;
      if (out0_ready && q0.size() > 0) void'(q0.pop_front());
      if (out1_ready && q1.size() > 0) void'(q1.pop_front());
      if (m_acc) begin
        if (s_sel) begin q1.push_back(s_data); m_cnt1++; end
        else       begin q0.push_back(s_data); m_cnt0++; end
      end
      m_ack = m_acc;
    end
  end

  // Delivered words and ack pulses, seen mid-cycle.
  logic [31:0] got0[$], got1[$];
  int          ack_pulses = 0;
  always @(negedge clk_arb) begin
    if (out0_valid && out0_ready) got0.push_back(out0_data);
    if (out1_valid && out1_ready) got1.push_back(out1_data);
    if (s_ack) ack_pulses++;
  end

  task automatic tick();
    @(posedge clk_arb);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_req = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    @(posedge clk_arb);
    @(posedge clk_arb);
    #1 rst_n = 1'b1;
    tick();
  endtask

  // Legal arbiter: hold request until ack is seen, keep it one more edge, then idle one edge.
  task automatic send(input logic sel, input logic [31:0] data);
    bit acked = 0;
    s_sel = sel;
    s_data = data;
    s_req = 1'b1;
    for (int i = 0; i < 40 && !acked; i++) begin
      tick();
      acked = s_ack;
    end
    if (!acked) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: no s_ack for sel=%0b data=%h within 40 cycles", sel, data);
    end
    tick();
    s_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (s_ack !== 1'b0)      begin n_fail++; $display("FAIL reset_ack: got %b want 0", s_ack); end
    n_chk++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_v0: got %b want 0", out0_valid); end
    n_chk++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_v1: got %b want 0", out1_valid); end
    n_chk++; if (acc_cnt0 !== '0)     begin n_fail++; $display("FAIL reset_cnt0: got %0d want 0", acc_cnt0); end
    n_chk++; if (acc_cnt1 !== '0)     begin n_fail++; $display("FAIL reset_cnt1: got %0d want 0", acc_cnt1); end
    n_chk++; if (proto_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b want 0", proto_err); end
  endtask

  task automatic test_single();
    do_reset();
    s_sel = 1'b0; s_data = 32'hDEADBEEF; s_req = 1'b1;
    n_chk++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pre: got %b want 0", s_ack); end
    tick();
    n_chk++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_rise: got %b want 1", s_ack); end
    tick();
    s_req = 1'b0;
    n_chk++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0", s_ack); end
    n_chk++; if (out0_valid !== 1'b1) begin n_fail++; $display("FAIL single_v0: got %b want 1", out0_valid); end
    n_chk++; if (out0_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_d0: got %h want deadbeef", out0_data); end
    n_chk++; if (acc_cnt0 !== 16'd1) begin n_fail++; $display("FAIL single_cnt0: got %0d want 1", acc_cnt0); end
    n_chk++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL single_v1: got %b want 0", out1_valid); end
    tick();
    n_chk++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_after: got %b want 0", s_ack); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 4; i++) send(1'b1, 32'(i));
    s_sel = 1'b1; s_data = 32'h5; s_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL bp_pending_ack: cycle %0d got %b want 0", i, s_ack); end
    end
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
    n_chk++; if (s_ack !== 1'b0) begin n_fail++; $display("FAIL bp_ack_on_pop: got %b want 0", s_ack); end
    n_chk++; if (out1_data !== 32'h2) begin n_fail++; $display("FAIL bp_head_after_pop: got %h want 2", out1_data); end
    tick();
    n_chk++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL bp_ack_after_pop: got %b want 1", s_ack); end
    tick();
    s_req = 1'b0;
    n_chk++; if (acc_cnt1 !== 16'd5) begin n_fail++; $display("FAIL bp_cnt1: got %0d want 5", acc_cnt1); end
    out1_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      n_chk++;
      if (out1_valid !== 1'b1 || out1_data !== 32'(i)) begin
        n_fail++; $display("FAIL bp_drain: got v=%b d=%h want v=1 d=%h", out1_valid, out1_data, 32'(i));
      end
      tick();
    end
    n_chk++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out1_valid); end
    out1_ready = 1'b0;
  endtask

  task automatic test_alternate();
    do_reset();
    got0.delete(); got1.delete();
    ack_pulses = 0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(1'(i % 2), 32'hA0 + 32'(i));
    repeat (3) tick();
    n_chk++; if (got0.size() != 2 || got0[0] !== 32'hA0 || got0[1] !== 32'hA2) begin
      n_fail++; $display("FAIL alt_ch0: got %0d words, first %h, want A0,A2", got0.size(), got0.size() > 0 ? got0[0] : 32'hx);
    end
    n_chk++; if (got1.size() != 2 || got1[0] !== 32'hA1 || got1[1] !== 32'hA3) begin
      n_fail++; $display("FAIL alt_ch1: got %0d words, first %h, want A1,A3", got1.size(), got1.size() > 0 ? got1[0] : 32'hx);
    end
    n_chk++; if (acc_cnt0 !== 16'd2 || acc_cnt1 !== 16'd2) begin
      n_fail++; $display("FAIL alt_cnt: got %0d/%0d want 2/2", acc_cnt0, acc_cnt1);
    end
    n_chk++; if (ack_pulses != 4) begin n_fail++; $display("FAIL alt_acks: got %0d want 4", ack_pulses); end
  endtask

  task automatic test_push_pop();
    do_reset();
    send(1'b0, 32'hB0);
    send(1'b0, 32'hB1);
    s_sel = 1'b0; s_data = 32'hB2; s_req = 1'b1; out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    n_chk++; if (s_ack !== 1'b1) begin n_fail++; $display("FAIL pp_ack: got %b want 1", s_ack); end
    n_chk++; if (out0_data !== 32'hB1) begin n_fail++; $display("FAIL pp_head: got %h want b1", out0_data); end
    tick();
    s_req = 1'b0;
    out0_ready = 1'b1;
    n_chk++; if (out0_valid !== 1'b1 || out0_data !== 32'hB1) begin n_fail++; $display("FAIL pp_drain0: got v=%b d=%h want b1", out0_valid, out0_data); end
    tick();
    n_chk++; if (out0_valid !== 1'b1 || out0_data !== 32'hB2) begin n_fail++; $display("FAIL pp_drain1: got v=%b d=%h want b2", out0_valid, out0_data); end
    tick();
    n_chk++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL pp_occ2: got v=%b want 0", out0_valid); end
    out0_ready = 1'b0;
  endtask

  task automatic test_proto_err();
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b0, 32'hC0 + 32'(i));
    s_sel = 1'b0; s_data = 32'hCC; s_req = 1'b1;
    tick();
    n_chk++; if (s_ack !== 1'b0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL pe_before: got ack=%b err=%b want 0/0", s_ack, proto_err); end
    s_req = 1'b0;
    tick();
    n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL pe_set: got %b want 1", proto_err); end
    out1_ready = 1'b1;
    send(1'b1, 32'hD0);
    send(1'b1, 32'hD1);
    n_chk++; if (proto_err !== 1'b1 || acc_cnt1 !== 16'd2) begin n_fail++; $display("FAIL pe_sticky: got err=%b cnt1=%0d want 1/2", proto_err, acc_cnt1); end
    do_reset();
    n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL pe_clear: got %b want 0", proto_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) send(1'b0, 32'hE0 + 32'(i));
    s_sel = 1'b0; s_data = 32'hEE; s_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (s_ack !== 1'b0 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
      n_fail++; $display("FAIL ar_outputs: got ack=%b v0=%b v1=%b want 0", s_ack, out0_valid, out1_valid);
    end
    n_chk++; if (acc_cnt0 !== '0 || acc_cnt1 !== '0 || proto_err !== 1'b0) begin
      n_fail++; $display("FAIL ar_state: got cnt0=%0d cnt1=%0d err=%b want 0", acc_cnt0, acc_cnt1, proto_err);
    end
    s_req = 1'b0;
    @(posedge clk_arb);
    #1 rst_n = 1'b1;
    tick();
    send(1'b0, 32'h66);
    n_chk++; if (acc_cnt0 !== 16'd1 || out0_valid !== 1'b1 || out0_data !== 32'h66) begin
      n_fail++; $display("FAIL ar_fresh: got cnt0=%0d v0=%b d0=%h want 1/1/66", acc_cnt0, out0_valid, out0_data);
    end
  endtask

  task automatic test_random();
    int phase = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      tick();
      n_chk++; if (s_ack !== m_ack) begin n_fail++; $display("FAIL rnd_ack: cyc %0d got %b want %b", cyc, s_ack, m_ack); end
      n_chk++; if (out0_valid !== (q0.size() != 0) || (q0.size() != 0 && out0_data !== q0[0])) begin
        n_fail++; $display("FAIL rnd_ch0: cyc %0d got v=%b d=%h want v=%b", cyc, out0_valid, out0_data, q0.size() != 0);
      end
      n_chk++; if (out1_valid !== (q1.size() != 0) || (q1.size() != 0 && out1_data !== q1[0])) begin
        n_fail++; $display("FAIL rnd_ch1: cyc %0d got v=%b d=%h want v=%b", cyc, out1_valid, out1_data, q1.size() != 0);
      end
      n_chk++; if (acc_cnt0 !== m_cnt0 || acc_cnt1 !== m_cnt1 || proto_err !== m_err) begin
        n_fail++; $display("FAIL rnd_cnt: cyc %0d got %0d/%0d err=%b want %0d/%0d err=%b", cyc, acc_cnt0, acc_cnt1, proto_err, m_cnt0, m_cnt1, m_err);
      end
      if (phase == 2) begin
        s_req = 1'b0;
        phase = 0;
      end else if (phase == 1 && s_ack) begin
        phase = 2;
      end else if (phase == 0 && $urandom_range(0, 1) == 0) begin
        s_sel = 1'($urandom_range(0, 1));
        s_data = $urandom;
        s_req = 1'b1;
        phase = 1;
      end
    end
    s_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_alternate();
    test_push_pop();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
